cdb_arbiter: RTL and testbench

//  Sits downstream of the per-unit CDB result FIFOs (ALU, MUL, LSU).

---
 rtl/cdb_arbiter_pkg.sv | 11 +
 rtl/cdb_arbiter_rr_arbiter.sv | 27 ++
 rtl/cdb_arbiter.sv | 61 ++++++
 tb/tb_cdb_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: CDB payload type and result-source indices shared by the CDB arbiter
package cdb_arbiter_pkg;
    localparam int N_CDB_SRC   = 3;
    localparam int CDB_SRC_ALU = 0;
    localparam int CDB_SRC_MUL = 1;
    localparam int CDB_SRC_LSU = 2;
    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] value;
    } cdb_struct_t;
endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// cdb_arbiter_rr_arbiter: combinational round-robin grant; req/ptr in, one-hot gnt and its index out
module cdb_arbiter_rr_arbiter #(
    parameter int N = 3,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);
    int j;
    // Scan from the farthest offset down so the request nearest ptr overwrites the rest.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        j       = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            j = (j >= N) ? j - N : j;
            if (req[j]) begin
                gnt     = '0;
                gnt[j]  = 1'b1;
                gnt_idx = W'(j);
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin pop of per-unit result FIFOs onto a single registered CDB
//   flush_i kills same-cycle pops and the entry popped last cycle; src_empty_i/src_data_i
//   come from the FIFOs, src_rd_o pops them; cdb_o/cdb_valid_o/cdb_src_o is the broadcast,
//   bcast_cnt_o counts broadcasts since reset.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_SRC = N_CDB_SRC,
    parameter int SRC_W = $clog2(N_SRC),
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic [N_SRC-1:0]        src_empty_i,
    input  cdb_struct_t [N_SRC-1:0] src_data_i,
    output logic [N_SRC-1:0]        src_rd_o,
    output cdb_struct_t             cdb_o,
    output logic                    cdb_valid_o,
    output logic [SRC_W-1:0]        cdb_src_o,
    output logic [CNT_W-1:0]        bcast_cnt_o
);
    logic [N_SRC-1:0] req, gnt;
    logic [SRC_W-1:0] rr_ptr, gnt_idx, s1_src;
    logic             s1_vld, cap;

    assign req      = ~src_empty_i & {N_SRC{~flush_i}};
    assign src_rd_o = rst ? '0 : gnt;
    // FIFO data appears the cycle after the pop, so capture happens one stage later.
    assign cap      = s1_vld && !flush_i;

    cdb_arbiter_rr_arbiter #(.N(N_SRC), .W(SRC_W)) u_rr (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            s1_vld      <= 1'b0;
            s1_src      <= '0;
            cdb_o       <= '0;
            cdb_valid_o <= 1'b0;
            cdb_src_o   <= '0;
            bcast_cnt_o <= '0;
        end else begin
            if (|gnt)
                rr_ptr <= (gnt_idx == SRC_W'(N_SRC - 1)) ? '0 : gnt_idx + 1'b1;
            s1_vld      <= |gnt;
            s1_src      <= gnt_idx;
            cdb_valid_o <= cap;
            if (cap) begin
                cdb_o       <= src_data_i[s1_src];
                cdb_src_o   <= s1_src;
                bcast_cnt_o <= bcast_cnt_o + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    typedef struct { int src; int tag; int cyc; } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush_i = 1'b0;
    logic [2:0]        src_empty_i = 3'b111;
    logic [2:0]        src_rd_o;
    cdb_struct_t [2:0] src_data_i = '0;
    cdb_struct_t       cdb_o;
    logic              cdb_valid_o;
    logic [1:0]        cdb_src_o;
    logic [31:0]       bcast_cnt_o;
    logic [5:0]        ntag [3] = '{6'd5, 6'd16, 6'd32};
    int                cyc = 0;
    int                nvec = 0;
    int                nerr = 0;
    exp_t              exp_q [$];
    exp_t              e;

    cdb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .src_empty_i (src_empty_i),
        .src_data_i  (src_data_i),
        .src_rd_o    (src_rd_o),
        .cdb_o       (cdb_o),
        .cdb_valid_o (cdb_valid_o),
        .cdb_src_o   (cdb_src_o),
        .bcast_cnt_o (bcast_cnt_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO stand-in: each pop presents the next tag of that source on the following cycle.
    always @(posedge clk)
        for (int k = 0; k < 3; k++)
            if (src_rd_o[k]) begin
                src_data_i[k] <= '{tag: ntag[k], value: 32'(ntag[k])};
                ntag[k]       <= ntag[k] + 6'd1;
            end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (cdb_valid_o) begin
                nvec++;
                if (exp_q.size() == 0) begin
                    nerr++;
                    $display("FAIL bcast: got src=%0d tag=%0d at cycle %0d, required no broadcast",
                             cdb_src_o, cdb_o.tag, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (cdb_src_o != 2'(e.src) || cdb_o.tag != 6'(e.tag) ||
                        cdb_o.value != 32'(e.tag) || cyc != e.cyc) begin
                        nerr++;
                        $display("FAIL bcast: got src=%0d tag=%0d value=%0d cycle=%0d, required src=%0d tag=%0d cycle=%0d",
                                 cdb_src_o, cdb_o.tag, cdb_o.value, cyc, e.src, e.tag, e.cyc);
                    end
                end
            end
        end
    endtask

    task automatic drive(input logic [2:0] emp, input logic fl, input logic [2:0] rd);
        src_empty_i = emp;
        flush_i     = fl;
        #1;
        check("src_rd_o", 64'(src_rd_o), 64'(rd));
        @(posedge clk);
        #1;
    endtask

    task automatic expect_b(input int s, input int t);
        exp_q.push_back('{s, t, cyc + 2});
    endtask

    task automatic idle(input int n);
        repeat (n) drive(3'b111, 1'b0, 3'b000);
    endtask

    task automatic drain(input int cnt);
        check("pending", 64'(exp_q.size()), 64'd0);
        check("bcast_cnt_o", 64'(bcast_cnt_o), 64'(cnt));
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        src_empty_i = 3'b000;
        flush_i     = 1'b0;
        #1;
        check("src_rd_o in reset", 64'(src_rd_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        fork
            monitor();
        join_none
        @(posedge clk);
        #1;
        do_reset();
        check("cdb_valid_o reset", 64'(cdb_valid_o), 64'd0);
        check("cdb_src_o reset", 64'(cdb_src_o), 64'd0);
        check("cdb_o reset", 64'(cdb_o), 64'd0);
        check("bcast_cnt_o reset", 64'(bcast_cnt_o), 64'd0);
        // all FIFOs empty
        idle(10);
        check("cdb_valid_o idle", 64'(cdb_valid_o), 64'd0);
        drain(0);
        // single ALU pop, ptr ends at 1
        expect_b(0, 5); drive(3'b110, 1'b0, 3'b001);
        idle(3);
        drain(1);
        // full rotation from ptr 0
        do_reset();
        expect_b(0, 6);  drive(3'b000, 1'b0, 3'b001);
        expect_b(1, 16); drive(3'b000, 1'b0, 3'b010);
        expect_b(2, 32); drive(3'b000, 1'b0, 3'b100);
        expect_b(0, 7);  drive(3'b000, 1'b0, 3'b001);
        expect_b(1, 17); drive(3'b000, 1'b0, 3'b010);
        expect_b(2, 33); drive(3'b000, 1'b0, 3'b100);
        idle(3);
        drain(6);
        // flush while a broadcast is already on the bus: it completes
        expect_b(0, 8); drive(3'b110, 1'b0, 3'b001);
        drive(3'b111, 1'b0, 3'b000);
        drive(3'b111, 1'b1, 3'b000);
        idle(2);
        drain(7);
        // MUL pop killed by flush next cycle; flush also blocks pops; ptr ends at 2
        drive(3'b101, 1'b0, 3'b010);
        drive(3'b000, 1'b1, 3'b000);
        idle(3);
        drain(7);
        // ptr=2, only ALU/MUL requesting: wrap to ALU, then MUL, then LSU from ptr 2
        expect_b(0, 9);  drive(3'b100, 1'b0, 3'b001);
        expect_b(1, 19); drive(3'b100, 1'b0, 3'b010);
        expect_b(2, 34); drive(3'b000, 1'b0, 3'b100);
        idle(3);
        drain(10);
        // reset one cycle after a pop drops it
        drive(3'b110, 1'b0, 3'b001);
        do_reset();
        idle(3);
        check("cdb_valid_o after reset", 64'(cdb_valid_o), 64'd0);
        drain(0);
        // ptr back at 0, then back-to-back pops of the same source
        expect_b(0, 11); drive(3'b000, 1'b0, 3'b001);
        expect_b(0, 12); drive(3'b110, 1'b0, 3'b001);
        expect_b(0, 13); drive(3'b110, 1'b0, 3'b001);
        idle(3);
        drain(3);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
